// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner and its consumers.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } kp_state_t;

  // Legacy 4x4 digit labels; positions without a digit map to 15.
  function automatic logic [3:0] kp_4x4_label(input logic [3:0] key_index);
    logic [3:0] lbl;
    case (key_index)
      4'd0:    lbl = 4'd1;
      4'd1:    lbl = 4'd2;
      4'd2:    lbl = 4'd3;
      4'd3:    lbl = 4'd10;
      4'd4:    lbl = 4'd4;
      4'd5:    lbl = 4'd5;
      4'd6:    lbl = 4'd6;
      4'd7:    lbl = 4'd11;
      4'd8:    lbl = 4'd7;
      4'd9:    lbl = 4'd8;
      4'd10:   lbl = 4'd9;
      4'd11:   lbl = 4'd12;
      4'd12:   lbl = 4'd15;
      4'd13:   lbl = 4'd0;
      4'd14:   lbl = 4'd15;
      default: lbl = 4'd13;
    endcase
    return lbl;
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Scan-rate clock enable: one-cycle tick every CLK_DIV cycles of clk_50.
module keypad_tick_gen #(
  parameter int CLK_DIV = 25000
) (
  input  logic clk_50,
  input  logic reset_n,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_W'(CLK_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_50) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column drive, row sync/debounce, key delivery over valid/ready.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int CLK_DIV  = 25000,
  parameter int DEBOUNCE = 4,
  parameter int KEY_W    = $clog2(ROWS * COLS)
) (
  input  logic             clk_50,
  input  logic             reset_n,
  input  logic [ROWS-1:0]  row,
  output logic [COLS-1:0]  column,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             key_held,
  output logic             key_overrun
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  logic             tick;
  logic [ROWS-1:0]  sync1_q, sync2_q;
  kp_state_t        state_q, state_d;
  logic [ROW_W-1:0] row_idx_q, row_idx_d;
  logic [COL_W-1:0] col_idx_q, col_idx_d;
  logic [COLS-1:0]  column_q, column_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [KEY_W-1:0] key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic             key_overrun_q, key_overrun_d;
  logic             samp_idle, samp_single;
  logic [ROW_W-1:0] samp_idx;
  logic             accept, release_key, advance;

  keypad_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_50  (clk_50),
    .reset_n (reset_n),
    .tick    (tick)
  );

  always_comb begin
    samp_idle   = (sync2_q == '0);
    samp_single = $onehot(sync2_q);
    samp_idx    = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (sync2_q[r]) samp_idx = ROW_W'(r);
    end
  end

  always_comb begin
    state_d       = state_q;
    row_idx_d     = row_idx_q;
    col_idx_d     = col_idx_q;
    cnt_d         = cnt_q;
    cnt_inc       = cnt_q + 1'b1;
    key_code_d    = key_code_q;
    key_valid_d   = key_valid_q;
    key_held_d    = key_held_q;
    key_overrun_d = 1'b0;
    accept        = 1'b0;
    release_key   = 1'b0;
    advance       = 1'b0;

    if (key_valid_q && key_ready) key_valid_d = 1'b0;

    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (samp_single) begin
            row_idx_d = samp_idx;
            cnt_d     = CNT_W'(1);
            if (DEBOUNCE == 1) accept = 1'b1;
            else               state_d = ST_DEBOUNCE;
          end else begin
            advance = 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (samp_single && samp_idx == row_idx_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(DEBOUNCE)) accept = 1'b1;
          end else if (samp_single) begin
            row_idx_d = samp_idx;
            cnt_d     = CNT_W'(1);
          end else begin
            state_d = ST_SCAN;
          end
        end
        ST_PRESSED: begin
          if (samp_idle) begin
            cnt_d = CNT_W'(1);
            if (DEBOUNCE == 1) release_key = 1'b1;
            else               state_d = ST_RELEASE;
          end
        end
        default: begin
          if (samp_idle) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(DEBOUNCE)) release_key = 1'b1;
          end else begin
            state_d = ST_PRESSED;
          end
        end
      endcase
    end

    // A consume in the same cycle frees the slot, so the new key wins.
    if (accept) begin
      state_d    = ST_PRESSED;
      key_held_d = 1'b1;
      if (!key_valid_q || key_ready) begin
        key_code_d  = KEY_W'(int'(samp_idx) * COLS + int'(col_idx_q));
        key_valid_d = 1'b1;
      end else begin
        key_overrun_d = 1'b1;
      end
    end

    if (release_key) begin
      state_d    = ST_SCAN;
      key_held_d = 1'b0;
      advance    = 1'b1;
    end

    if (advance) begin
      col_idx_d = (col_idx_q == COL_W'(COLS - 1)) ? '0 : col_idx_q + 1'b1;
    end
    column_d = ~(COLS'(1) << col_idx_d);
  end

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      state_q       <= ST_SCAN;
      row_idx_q     <= '0;
      col_idx_q     <= '0;
      column_q      <= ~COLS'(1);
      cnt_q         <= '0;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_held_q    <= 1'b0;
      key_overrun_q <= 1'b0;
    end else begin
      sync1_q       <= row;
      sync2_q       <= sync1_q;
      state_q       <= state_d;
      row_idx_q     <= row_idx_d;
      col_idx_q     <= col_idx_d;
      column_q      <= column_d;
      cnt_q         <= cnt_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_held_q    <= key_held_d;
      key_overrun_q <= key_overrun_d;
    end
  end

  assign column      = column_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_held    = key_held_q;
  assign key_overrun = key_overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: 4x4 matrix model, CLK_DIV=4, DEBOUNCE=3.
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic       clk_50 = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] row;
  logic [3:0] column;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       key_held;
  logic       key_overrun;

  logic [15:0] keys_down = '0;
  logic        raw_mode = 1'b0;
  logic [3:0]  raw_row = '0;
  logic [3:0]  model_row;

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  logic ovr_prev = 1'b0;
  logic [3:0] sb_q[$];

  always #5 clk_50 = ~clk_50;

  keypad_scanner #(.ROWS(4), .COLS(4), .CLK_DIV(4), .DEBOUNCE(3)) dut (
    .clk_50      (clk_50),
    .reset_n     (reset_n),
    .row         (row),
    .column      (column),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_held    (key_held),
    .key_overrun (key_overrun)
  );

  // A pressed key shorts its row to its column while that column is driven low.
  always_comb begin
    model_row = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys_down[r*4+c] && !column[c]) model_row[r] = 1'b1;
  end
  assign row = raw_mode ? raw_row : model_row;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk_50) begin
    if (reset_n) begin
      if (key_valid && key_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_key actual=%0d required=none", key_code);
        end else begin
          logic [3:0] exp;
          exp = sb_q.pop_front();
          if (key_code !== exp) begin
            errors++;
            $display("FAIL key_code actual=%0d required=%0d", key_code, exp);
          end
        end
      end
      if (key_overrun) begin
        ovr_cnt++;
        if (ovr_prev) begin
          checks++;
          errors++;
          $display("FAIL overrun_width actual=2+ required=1");
        end
      end
      ovr_prev = key_overrun;
    end else begin
      ovr_prev = 1'b0;
    end
  end

  task automatic wait_tick();
    int n = 0;
    @(negedge clk_50);
    while (!dut.u_tick.tick && n < 20) begin
      @(negedge clk_50);
      n++;
    end
    @(posedge clk_50);
    #1;
  endtask

  task automatic wait_sig(input string name, input logic want_valid, input logic lvl, input int max);
    int n = 0;
    @(negedge clk_50);
    while (((want_valid ? key_valid : key_held) !== lvl) && n < max) begin
      @(negedge clk_50);
      n++;
    end
    chk(name, want_valid ? key_valid : key_held, lvl);
  endtask

  task automatic enter_reset(input int cycles);
    reset_n = 1'b0;
    repeat (cycles) @(posedge clk_50);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // Reset state and column stepping
    enter_reset(5);
    chk("rst_column", column, 4'b1110);
    chk("rst_valid", key_valid, 0);
    chk("rst_held", key_held, 0);
    chk("rst_code", key_code, 0);
    chk("rst_ovr", key_overrun, 0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk_50);
    #1 chk("col_before_tick", column, 4'b1110);
    @(posedge clk_50); #1 chk("col_step1", column, 4'b1101);
    repeat (4) @(posedge clk_50); #1 chk("col_step2", column, 4'b1011);
    repeat (4) @(posedge clk_50); #1 chk("col_step3", column, 4'b0111);
    repeat (4) @(posedge clk_50); #1 chk("col_wrap", column, 4'b1110);

    // Clean press of key 6 (row1, col2)
    key_ready = 1'b1;
    chk("label6", 32'(kp_4x4_label(4'd6)), 6);
    chk("label3", 32'(kp_4x4_label(4'd3)), 10);
    chk("label13", 32'(kp_4x4_label(4'd13)), 0);
    sb_q.push_back(4'd6);
    keys_down[6] = 1'b1;
    wait_sig("press6_valid", 1'b1, 1'b1, 200);
    chk("press6_held_with_valid", key_held, 1);
    repeat (6) wait_tick();
    chk("press6_held", key_held, 1);
    keys_down = '0;
    wait_tick(); wait_tick();
    chk("held_after_2_idle", key_held, 1);
    wait_tick();
    chk("held_after_3_idle", key_held, 0);
    chk("valid_consumed", key_valid, 0);

    // Bounce on column 0: samples P,I,P,I,P then steady P
    enter_reset(2);
    key_ready = 1'b0;
    raw_mode = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      raw_row = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      wait_tick();
    end
    raw_row = 4'b0010;
    wait_tick();
    chk("bounce_not_early", key_valid, 0);
    wait_tick();
    chk("bounce_accept", key_valid, 1);
    chk("bounce_code", key_code, 4);
    sb_q.push_back(4'd4);
    raw_row = 4'b0000;
    @(posedge clk_50); #1 key_ready = 1'b1;
    repeat (3) wait_tick();
    chk("bounce_release", key_held, 0);
    raw_mode = 1'b0;

    // Backpressure: key 1 then key 9 while key 1 is still pending
    key_ready = 1'b0;
    ovr_cnt = 0;
    sb_q.push_back(4'd1);
    keys_down[1] = 1'b1;
    wait_sig("bp_key1_valid", 1'b1, 1'b1, 200);
    repeat (2) wait_tick();
    keys_down = '0;
    wait_sig("bp_key1_release", 1'b0, 1'b0, 200);
    keys_down[9] = 1'b1;
    wait_sig("bp_key9_held", 1'b0, 1'b1, 200);
    repeat (2) wait_tick();
    keys_down = '0;
    wait_sig("bp_key9_release", 1'b0, 1'b0, 200);
    chk("bp_ovr_count", ovr_cnt, 1);
    chk("bp_code_kept", key_code, 1);
    chk("bp_valid_kept", key_valid, 1);
    @(posedge clk_50); #1 key_ready = 1'b1;
    @(posedge clk_50); #1 chk("bp_valid_clear", key_valid, 0);

    // Multi-key: rows 0 and 1 on column 3
    begin
      int changes = 0;
      logic seen_valid = 1'b0;
      logic [3:0] prev_col;
      keys_down[3] = 1'b1;
      keys_down[7] = 1'b1;
      @(negedge clk_50);
      prev_col = column;
      for (int i = 0; i < 64; i++) begin
        @(negedge clk_50);
        if (column != prev_col) changes++;
        if (key_valid || key_held) seen_valid = 1'b1;
        prev_col = column;
      end
      chk("multi_no_accept", seen_valid, 0);
      chk("multi_col_advances", changes, 16);
      keys_down = '0;
    end

    // Reset while PRESSED with a pending key
    key_ready = 1'b0;
    keys_down[5] = 1'b1;
    wait_sig("mid_valid", 1'b1, 1'b1, 200);
    wait_tick();
    chk("mid_held", key_held, 1);
    keys_down = '0;
    enter_reset(1);
    chk("mid_rst_valid", key_valid, 0);
    chk("mid_rst_held", key_held, 0);
    chk("mid_rst_code", key_code, 0);
    chk("mid_rst_column", column, 4'b1110);
    reset_n = 1'b1;
    repeat (3) @(posedge clk_50);
    #1 chk("mid_restart_hold", column, 4'b1110);
    @(posedge clk_50); #1 chk("mid_restart_step", column, 4'b1101);

    repeat (8) @(posedge clk_50);
    chk("sb_drained", sb_q.size(), 0);
    chk("ovr_total", ovr_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner that replaces the fixed 4x4 digit reader. It drives one active-low column per scan tick and synchronises and debounces the row inputs. Each accepted press is delivered as a key index over a valid/ready handshake, with release detection and overrun reporting. It sits between the keypad pins and the PIN-entry/lock controller, and runs entirely on `clk_50` using a clock enable; no derived clocks.

## Interface
- `ROWS`, default 4: number of row sense inputs.
- `COLS`, default 4: number of column drive outputs.
- `CLK_DIV`, default 25000: `clk_50` cycles per scan tick, ≥ 2.
- `DEBOUNCE`, default 4: consecutive identical tick samples required to accept a press or a release, ≥ 1.
- `KEY_W`, default `$clog2(ROWS*COLS)`: width of the key index.

- `clk_50` in 1: the only clock.
- `reset_n` in 1: reset, synchronous and active-low.
- `row` in ROWS: row sense, active-high, asynchronous to `clk_50`.
- `column` out COLS: column drive, active-low, exactly one bit low at all times.
- `key_code` out KEY_W: accepted key index, `row_idx*COLS + col_idx`.
- `key_valid` out 1: `key_code` holds an unconsumed key.
- `key_ready` in 1: consumer accepts the key.
- `key_held` out 1: an accepted key is still physically down.
- `key_overrun` out 1: one-cycle pulse when a press is dropped because `key_valid` was still high.

## Operation
- Input synchronisation: `row` passes through a 2-flop synchroniser. Samples are taken only on `tick`.
- Tick generation: the divider counts 0..CLK_DIV-1 and `tick` pulses for one cycle at the terminal count.
- Sample validity:
  - A sample is valid-single when exactly one row bit is set, giving `row_idx`.
  - A sample is idle when it is zero.
  - Otherwise it is a multi-key sample, which is ignored.
- FSM states:
  - SCAN: on `tick`:
    - valid-single: latch `row_idx`, set cnt=1, go to DEBOUNCE; `column` does not move.
    - otherwise: advance `column` to the next index, wrapping from COLS-1 to 0.
  - DEBOUNCE: on `tick`:
    - same `row_idx`: cnt++. When cnt reaches DEBOUNCE, accept the key and go to PRESSED.
    - different valid-single: re-latch `row_idx`, set cnt=1.
    - idle or multi-key: go to SCAN.
    - DEBOUNCE=1 accepts on the first sample, passing straight from SCAN to PRESSED.
  - PRESSED: `key_held`=1. On `tick` with an idle sample, set cnt=1 and go to RELEASE.
  - RELEASE: on `tick`:
    - idle: cnt++. When cnt reaches DEBOUNCE, clear `key_held`, advance `column`, go to SCAN.
    - non-idle: return to PRESSED.
- Accept:
  - If `key_valid`=0: load `key_code`, set `key_valid`=1.
  - Else: keep the old `key_code` and pulse `key_overrun`. The key is still tracked through PRESSED/RELEASE.
- Handshake:
  - `key_valid` clears on the edge where `key_valid && key_ready`.
  - If accept and consume happen in the same cycle, the new key wins: `key_valid` stays 1 and `key_code` takes the new value.
  - `key_ready` while `key_valid`=0 is ignored.
- Mid-operation reset: the next edge with `reset_n`=0 returns everything to the reset values. Any pending key is discarded.

## Timing
- Reset values:
  - state = SCAN, `column` = all ones except bit 0 low.
  - `key_code` = 0, `key_valid` = 0, `key_held` = 0, `key_overrun` = 0.
  - divider = 0, debounce count = 0, synchroniser = 0.
- First `tick` occurs CLK_DIV cycles after reset is released.
- `column` changes only on the cycle after a `tick`. Each row sample therefore sees a column driven for a full tick period.
- Press-to-valid latency: DEBOUNCE ticks after the first valid-single sample, plus 1 cycle. The synchroniser adds 2 cycles to input visibility.
- `key_held` rises together with `key_valid`, or at the same edge on overrun. It falls one cycle after the DEBOUNCE-th idle tick.
- `key_overrun` is high for exactly one `clk_50` cycle.

## Structure
- Package `keypad_pkg` holds:
  - the FSM state enum `kp_state_t` (SCAN, DEBOUNCE, PRESSED, RELEASE);
  - function `kp_4x4_label(key_index)`, which maps index to the legacy digit codes: row0 {1,2,3,10}, row1 {4,5,6,11}, row2 {7,8,9,12}, row3 {15,0,15,13}. Consumers use it; the scanner itself outputs only indices.
- One sub-module, `keypad_tick_gen`: parametrised by CLK_DIV, with ports `clk_50`, `reset_n` and `tick` out.

## Test plan
Bench parameters: CLK_DIV=4, DEBOUNCE=3, 4x4.
1. Reset: hold `reset_n`=0 for 5 cycles. `column`=4'b1110 and all outputs are 0. Release reset: `column` steps 1101, 1011, 0111, 1110 every 4 cycles.
2. Clean press: drive `row`=4'b0010 only while `column`=4'b1011 and for ≥ 6 ticks, `key_ready`=1. Expect one `key_valid` with `key_code`=6, and `kp_4x4_label(6)`=6. `key_held`=1 until 3 idle ticks after release.
3. Bounce: toggle `row` 0010/0000 every tick for 5 ticks, then hold. Exactly one accept, 3 ticks after the stable hold begins.
4. Backpressure: `key_ready`=0. Press key 1, release, then press key 9. `key_code` stays 1, `key_overrun` pulses once, and after `key_ready`=1 `key_valid` clears one cycle later.
5. Multi-key: `row`=4'b0011 on the active column. There is no accept, and `column` keeps advancing.
6. Reset mid-press in PRESSED with `key_valid`=1. The next edge clears everything, and scanning restarts at column 0.
